// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if: request/grant bundle between requesting ports
// and the round-robin arbiter.
interface rr_arbiter_if #(
  parameter int PORTS = 4
);
  localparam int W = $clog2(PORTS);

  logic [PORTS-1:0] request;
  logic [PORTS-1:0] acknowledge;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [W-1:0]     grant_encoded;
  logic             hold_timeout;

  modport master (
    output request,
    output acknowledge,
    input  grant,
    input  grant_valid,
    input  grant_encoded,
    input  hold_timeout
  );

  modport slave (
    input  request,
    input  acknowledge,
    output grant,
    output grant_valid,
    output grant_encoded,
    output hold_timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin arbiter over PORTS requesters.
// Forced release after MAX_HOLD cycles: RR_ARBITER_HOLD_TIMEOUT_EN.
module priority_encoder #(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]         input_unencoded,
  output logic                     output_valid,
  output logic [$clog2(WIDTH)-1:0] output_encoded,
  output logic [WIDTH-1:0]         output_unencoded
);
  localparam int W = $clog2(WIDTH);

  always_comb begin
    output_encoded = '0;
    if (LSB_PRIORITY == "LOW") begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (input_unencoded[i]) output_encoded = W'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (input_unencoded[i]) output_encoded = W'(i);
    end
  end

  assign output_valid = |input_unencoded;
  assign output_unencoded = output_valid ?
    (WIDTH'(1) << output_encoded) : '0;
endmodule

module rr_arbiter #(
  parameter int    PORTS        = 4,
  parameter string BLOCK        = "NONE",
  parameter string LSB_PRIORITY = "LOW",
  parameter int    MAX_HOLD     = 16
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter_if.slave arb
);
  localparam int W = $clog2(PORTS);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state;
  logic [PORTS-1:0] grant;
  logic [PORTS-1:0] mask;
  logic [PORTS-1:0] mask_next;
  logic [PORTS-1:0] cand;
  logic [PORTS-1:0] masked;
  logic [PORTS-1:0] u_oh;
  logic [PORTS-1:0] m_oh;
  logic [PORTS-1:0] win_oh;
  logic [W-1:0]     enc;
  logic [W-1:0]     u_enc;
  logic [W-1:0]     m_enc;
  logic [W-1:0]     win;
  logic             valid;
  logic             u_vld;
  logic             m_vld;
  logic             req_hit;
  logic             ack_hit;
  logic             rel;
  logic             timeout;
  logic             rearb;

  assign req_hit = |(arb.request & grant);
  assign ack_hit = |(arb.acknowledge & grant);

  always_comb begin
    rel = 1'b1;
    if (BLOCK == "REQUEST")
      rel = !req_hit;
    else if (BLOCK == "ACKNOWLEDGE")
      rel = ack_hit;
  end

`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt;
  logic          hold;

  assign timeout = (BLOCK != "NONE") &&
                   (state == GRANTED) &&
                   (cnt == CW'(MAX_HOLD));
  assign arb.hold_timeout = hold;
`else
  assign timeout = 1'b0;
  assign arb.hold_timeout = 1'b0;
`endif

  assign rearb = (state == IDLE) || rel || timeout;

  // a timed-out holder sits out exactly one arbitration
  assign cand   = timeout ? (arb.request & ~grant) : arb.request;
  assign masked = cand & mask;

  priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_pe (
    .input_unencoded  (cand),
    .output_valid     (u_vld),
    .output_encoded   (u_enc),
    .output_unencoded (u_oh)
  );

  priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) m_pe (
    .input_unencoded  (masked),
    .output_valid     (m_vld),
    .output_encoded   (m_enc),
    .output_unencoded (m_oh)
  );

  assign win    = m_vld ? m_enc : u_enc;
  assign win_oh = m_vld ? m_oh : u_oh;

  always_comb begin
    mask_next = '0;
    for (int i = 0; i < PORTS; i++)
      mask_next[i] = (LSB_PRIORITY == "LOW") ?
        (i > int'(win)) : (i < int'(win));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      valid <= 1'b0;
      enc   <= '0;
      mask  <= '1;
`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
      cnt   <= '0;
      hold  <= 1'b0;
`endif
    end else begin
`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
      hold <= timeout;
      if (rearb)
        cnt <= '0;
      else if (BLOCK != "NONE")
        cnt <= cnt + 1'b1;
`endif
      if (rearb) begin
        if (u_vld) begin
          state <= GRANTED;
          grant <= win_oh;
          valid <= 1'b1;
          enc   <= win;
          mask  <= mask_next;
        end else begin
          state <= IDLE;
          grant <= '0;
          valid <= 1'b0;
        end
      end
    end
  end

  assign arb.grant         = grant;
  assign arb.grant_valid   = valid;
  assign arb.grant_encoded = enc;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: five arbiter configurations driven in parallel
// and compared every cycle against a cyclic-search reference.
module tb_rr_arbiter;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_if #(.PORTS(4)) b[N] ();

  logic [3:0] req[N];
  logic [3:0] ack[N];
  logic [3:0] g[N];
  logic [1:0] e[N];
  logic       v[N];
  logic       t[N];

  for (genvar i = 0; i < N; i++) begin : g_bus
    assign b[i].request     = req[i];
    assign b[i].acknowledge = ack[i];
    assign g[i] = b[i].grant;
    assign e[i] = b[i].grant_encoded;
    assign v[i] = b[i].grant_valid;
    assign t[i] = b[i].hold_timeout;
  end

  rr_arbiter #(.PORTS(4), .BLOCK("NONE"), .LSB_PRIORITY("LOW"),
    .MAX_HOLD(16)) dut0 (.clk(clk), .rst(rst), .arb(b[0]));
  rr_arbiter #(.PORTS(4), .BLOCK("NONE"), .LSB_PRIORITY("HIGH"),
    .MAX_HOLD(16)) dut1 (.clk(clk), .rst(rst), .arb(b[1]));
  rr_arbiter #(.PORTS(4), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW"),
    .MAX_HOLD(4)) dut2 (.clk(clk), .rst(rst), .arb(b[2]));
  rr_arbiter #(.PORTS(4), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW"),
    .MAX_HOLD(16)) dut3 (.clk(clk), .rst(rst), .arb(b[3]));
  rr_arbiter #(.PORTS(4), .BLOCK("REQUEST"), .LSB_PRIORITY("HIGH"),
    .MAX_HOLD(16)) dut4 (.clk(clk), .rst(rst), .arb(b[4]));

  // blk: 0 none, 1 request, 2 acknowledge
  int blk[N] = '{0, 0, 1, 2, 1};
  int hi[N]  = '{0, 1, 0, 0, 1};
  int mh[N]  = '{16, 16, 4, 16, 16};

  int m_last[N];
  int m_enc[N];
  int m_cnt[N];
  bit m_valid[N];
  bit m_to[N];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_valid[d] = 1'b0;
      m_enc[d]   = 0;
      m_cnt[d]   = 0;
      m_to[d]    = 1'b0;
      m_last[d]  = hi[d] != 0 ? 0 : 3;
    end
  endtask

  task automatic model_step(int d);
    bit to;
    bit rel;
    bit found;
    logic [3:0] cand;
    int p;
    to = 1'b0;
`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
    to = m_valid[d] && blk[d] != 0 && m_cnt[d] == mh[d];
`endif
    rel = !m_valid[d] || blk[d] == 0 || to ||
          (blk[d] == 1 && !req[d][m_enc[d]]) ||
          (blk[d] == 2 && ack[d][m_enc[d]]);
    m_to[d] = to;
    if (!rel) begin
      m_cnt[d]++;
    end else begin
      cand = req[d];
      if (to) cand[m_enc[d]] = 1'b0;
      m_valid[d] = 1'b0;
      m_cnt[d] = 0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        p = hi[d] != 0 ? (m_last[d] - k + 8) % 4 : (m_last[d] + k) % 4;
        if (!found && cand[p]) begin
          found = 1'b1;
          m_valid[d] = 1'b1;
          m_enc[d] = p;
          m_last[d] = p;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] eg;
    @(posedge clk);
    for (int d = 0; d < N; d++) model_step(d);
    #1;
    for (int d = 0; d < N; d++) begin
      eg = m_valid[d] ? 4'(1 << m_enc[d]) : 4'b0;
      check($sformatf("d%0d grant", d), g[d], eg);
      check($sformatf("d%0d valid", d), v[d], m_valid[d]);
      check($sformatf("d%0d enc", d), e[d], m_enc[d]);
      check($sformatf("d%0d timeout", d), t[d], m_to[d]);
    end
  endtask

  logic [3:0] x0[8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [3:0] x1[8] = '{4'h8, 4'h2, 4'h1, 4'h8, 4'h2, 4'h1, 4'h8, 4'h2};
  logic [3:0] x2[8] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4};
  logic [3:0] x3[8] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};

  initial begin
    int pulses;
    for (int d = 0; d < N; d++) begin
      req[d] = '0;
      ack[d] = '0;
    end
    model_reset();
    #12;
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d reset grant", d), g[d], 4'b0);
      check($sformatf("d%0d reset valid", d), v[d], 1'b0);
      check($sformatf("d%0d reset enc", d), e[d], 2'd0);
      check($sformatf("d%0d reset timeout", d), t[d], 1'b0);
    end
    rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      req[0] = 4'hF;
      req[1] = 4'hB;
      req[2] = c < 5 ? 4'h6 : 4'h4;
      req[3] = c == 0 ? 4'h4 : 4'h0;
      ack[3] = c == 7 ? 4'h4 : 4'h0;
      req[4] = 4'hD;
      cycle();
      check("plan rr low", g[0], x0[c]);
      check("plan rr low enc", e[0], c % 4);
      check("plan rr high", g[1], x1[c]);
      check("plan block req", g[2], x2[c]);
      check("plan block ack", g[3], x3[c]);
      check("plan block ack valid", v[3], c != 7);
    end

    for (int d = 0; d < N; d++) req[d] = 4'hF;
    cycle();
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d async grant", d), g[d], 4'b0);
      check($sformatf("d%0d async valid", d), v[d], 1'b0);
    end
    model_reset();
    #1 rst = 1'b0;
    for (int d = 0; d < N; d++) req[d] = 4'hC;
    cycle();
    check("post reset grant", g[0], 4'h4);

    for (int c = 0; c < 600; c++) begin
      for (int d = 0; d < N; d++) begin
        req[d] = req[d] ^ 4'($urandom & $urandom);
        ack[d] = 4'($urandom & $urandom & $urandom);
      end
      cycle();
    end

    #2 rst = 1'b1;
    model_reset();
    for (int d = 0; d < N; d++) begin
      req[d] = '0;
      ack[d] = '0;
    end
    #2 rst = 1'b0;
    req[2] = 4'h1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (t[2]) pulses++;
    end
`ifdef RR_ARBITER_HOLD_TIMEOUT_EN
    check("timeout pulses", pulses, 2);
`else
    check("timeout pulses", pulses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
